// File: rtl/axi_sram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi_sram_pkg
//  Description : Shared AXI response/burst encodings and the write/read state
//                encodings used by the AXI SRAM responder.
//  Revision    : 1.0 - initial release
// ============================================================================
package axi_sram_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

endpackage
`default_nettype wire

// File: rtl/axi_interface_if.sv
`default_nettype none
// ============================================================================
//  Module      : axi_interface_if
//  Description : AXI4 bus bundle. wr_slv/rd_slv are the responder views of the
//                AW/W/B and AR/R channels, wr_mst/rd_mst the requester views.
//  Revision    : 1.0 - initial release
// ============================================================================
interface axi_interface_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 64,
    parameter int ID_W   = 8
) ();
    import axi_sram_pkg::*;

    logic              awvalid, awready, awlock, awuser;
    logic [ID_W-1:0]   awid;
    logic [ADDR_W-1:0] awaddr;
    logic [7:0]        awlen;
    logic [2:0]        awsize, awprot;
    logic [1:0]        awburst;
    logic [3:0]        awcache, awqos, awregion;

    logic                wvalid, wready, wlast, wuser;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;

    logic            bvalid, bready, buser;
    logic [ID_W-1:0] bid;
    logic [1:0]      bresp;

    logic              arvalid, arready, arlock, aruser;
    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize, arprot;
    logic [1:0]        arburst;
    logic [3:0]        arcache, arqos, arregion;

    logic              rvalid, rready, rlast, ruser;
    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;

    modport wr_slv (
        input  awvalid, awid, awaddr, awlen, awsize, awburst, awlock, awcache,
               awprot, awqos, awregion, awuser, wvalid, wdata, wstrb, wlast,
               wuser, bready,
        output awready, wready, bvalid, bid, bresp, buser
    );
    modport rd_slv (
        input  arvalid, arid, araddr, arlen, arsize, arburst, arlock, arcache,
               arprot, arqos, arregion, aruser, rready,
        output arready, rvalid, rid, rdata, rresp, rlast, ruser
    );
    modport wr_mst (
        output awvalid, awid, awaddr, awlen, awsize, awburst, awlock, awcache,
               awprot, awqos, awregion, awuser, wvalid, wdata, wstrb, wlast,
               wuser, bready,
        input  awready, wready, bvalid, bid, bresp, buser
    );
    modport rd_mst (
        output arvalid, arid, araddr, arlen, arsize, arburst, arlock, arcache,
               arprot, arqos, arregion, aruser, rready,
        input  arready, rvalid, rid, rdata, rresp, rlast, ruser
    );
endinterface
`default_nettype wire

// File: rtl/axi_sram_mem.sv
`default_nettype none
// ============================================================================
//  Module      : axi_sram_mem
//  Description : 1-write / 1-read byte-strobed word array. The read port is
//                registered and read-first: a same-cycle write to the read
//                word returns the old contents. The read register holds its
//                value while i_re is low. The array itself is never reset.
//  Ports       : clk, rst_n        - clock, sync active-low reset (read reg)
//                i_we/i_waddr/i_wdata/i_wstrb - write port
//                i_re/i_raddr/o_rdata         - registered read port
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_sram_mem #(
    parameter int DATA_W = 64,
    parameter int WORDS  = 8192,
    parameter int IDX_W  = 13
) (
    input  wire logic                clk,
    input  wire logic                rst_n,
    input  wire logic                i_we,
    input  wire logic [IDX_W-1:0]    i_waddr,
    input  wire logic [DATA_W-1:0]   i_wdata,
    input  wire logic [DATA_W/8-1:0] i_wstrb,
    input  wire logic                i_re,
    input  wire logic [IDX_W-1:0]    i_raddr,
    output logic      [DATA_W-1:0]   o_rdata
);
    import axi_sram_pkg::*;

    logic [DATA_W-1:0] r_mem [WORDS];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < DATA_W/8; b++) begin
                if (i_wstrb[b]) r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)    r_rdata <= '0;
        else if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;
endmodule
`default_nettype wire

// File: rtl/axi_sram_slv.sv
`default_nettype none
// ============================================================================
//  Module      : axi_sram_slv
//  Description : AXI4 responder backed by an on-chip SRAM. Independent write
//                (AW/W/B) and read (AR/R) state machines; FIXED and INCR
//                bursts of full-width beats. Bursts with a bad size, WRAP/
//                reserved type or any beat outside the window are consumed
//                without touching memory and answered with SLVERR.
//  Ports       : clk, rst_n - clock, sync active-low reset
//                s_axi_wr   - AW/W/B responder
//                s_axi_rd   - AR/R responder
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_sram_slv #(
    parameter int                DATA_W    = 64,
    parameter int                ADDR_W    = 64,
    parameter int                ID_W      = 8,
    parameter int                MEM_BYTES = 65536,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    axi_interface_if.wr_slv s_axi_wr,
    axi_interface_if.rd_slv s_axi_rd
);
    import axi_sram_pkg::*;

    localparam int c_BYTES = DATA_W / 8;
    localparam int c_LSB   = $clog2(c_BYTES);
    localparam int c_WORDS = MEM_BYTES / c_BYTES;
    localparam int c_IDX_W = (c_WORDS > 1) ? $clog2(c_WORDS) : 1;
    localparam int c_AW1   = ADDR_W + 1;

    function automatic logic [ADDR_W-1:0] align(input logic [ADDR_W-1:0] a);
        return a & ~ADDR_W'(c_BYTES - 1);
    endfunction

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                    input logic [1:0] burst);
        return (burst == BURST_INCR) ? a + ADDR_W'(c_BYTES) : a;
    endfunction

    function automatic logic [c_IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
        return c_IDX_W'((a - BASE_ADDR) >> c_LSB);
    endfunction

    // One extra bit so an address below BASE_ADDR wraps to a huge offset
    // and an INCR end address past the top of the space cannot alias.
    function automatic logic in_range(input logic [c_AW1-1:0] a);
        return (a - {1'b0, BASE_ADDR}) < c_AW1'(MEM_BYTES);
    endfunction

    // The window is contiguous, so checking the first and last beat covers
    // every beat of a FIXED or INCR burst.
    function automatic logic burst_err(input logic [ADDR_W-1:0] addr, input logic [7:0] len,
                                       input logic [2:0] size, input logic [1:0] burst);
        logic [c_AW1-1:0] lo, hi;
        lo = {1'b0, align(addr)};
        hi = (burst == BURST_FIXED) ? lo : lo + (c_AW1'(len) << c_LSB);
        return (size != 3'(c_LSB)) || !(burst == BURST_FIXED || burst == BURST_INCR)
               || !in_range(lo) || !in_range(hi);
    endfunction

    // r_live holds both ready outputs low throughout reset and rises on the
    // first edge after release.
    logic r_live;

    // ---------------- write channel ----------------
    wr_state_t         r_wstate, w_wstate_nxt;
    logic [ID_W-1:0]   r_awid;
    logic [ADDR_W-1:0] r_waddr;
    logic [7:0]        r_wlen;
    logic [1:0]        r_wburst;
    logic [8:0]        r_wcnt;
    logic              r_werr, r_wlast_err;
    logic              w_aw_hs, w_w_hs, w_wfinal;

    assign w_aw_hs  = s_axi_wr.awvalid & s_axi_wr.awready;
    assign w_w_hs   = s_axi_wr.wvalid & s_axi_wr.wready;
    assign w_wfinal = (r_wcnt == {1'b0, r_wlen});

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_live   <= 1'b0;
            r_wstate <= W_IDLE;
        end else begin
            r_live   <= 1'b1;
            r_wstate <= w_wstate_nxt;
        end
    end

    always_comb begin
        w_wstate_nxt = r_wstate;
        case (r_wstate)
            W_IDLE:  if (w_aw_hs) w_wstate_nxt = W_DATA;
            W_DATA:  if (w_w_hs && w_wfinal) w_wstate_nxt = W_RESP;
            W_RESP:  if (s_axi_wr.bready) w_wstate_nxt = W_IDLE;
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        s_axi_wr.awready = r_live && (r_wstate == W_IDLE);
        s_axi_wr.wready  = (r_wstate == W_DATA);
        s_axi_wr.bvalid  = (r_wstate == W_RESP);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_awid <= '0; r_waddr <= '0; r_wlen <= '0; r_wburst <= '0;
            r_wcnt <= '0; r_werr <= 1'b0; r_wlast_err <= 1'b0;
        end else if (w_aw_hs) begin
            r_awid      <= s_axi_wr.awid;
            r_waddr     <= align(s_axi_wr.awaddr);
            r_wlen      <= s_axi_wr.awlen;
            r_wburst    <= s_axi_wr.awburst;
            r_wcnt      <= '0;
            r_werr      <= burst_err(s_axi_wr.awaddr, s_axi_wr.awlen,
                                     s_axi_wr.awsize, s_axi_wr.awburst);
            r_wlast_err <= 1'b0;
        end else if (w_w_hs) begin
            r_waddr <= next_addr(r_waddr, r_wburst);
            r_wcnt  <= r_wcnt + 9'd1;
            if (s_axi_wr.wlast != w_wfinal) r_wlast_err <= 1'b1;
        end
    end

    assign s_axi_wr.bid   = r_awid;
    assign s_axi_wr.bresp = (r_werr || r_wlast_err) ? RESP_SLVERR : RESP_OKAY;
    assign s_axi_wr.buser = 1'b0;

    // ---------------- read channel ----------------
    rd_state_t         r_rstate, w_rstate_nxt;
    logic [ID_W-1:0]   r_arid;
    logic [ADDR_W-1:0] r_raddr;
    logic [7:0]        r_rlen;
    logic [1:0]        r_rburst;
    logic [8:0]        r_rcnt;
    logic              r_rerr;
    logic              w_ar_hs, w_r_hs, w_rfinal, w_mem_re;
    logic [c_IDX_W-1:0] w_mem_raddr;
    logic [DATA_W-1:0]  w_mem_rdata;

    assign w_ar_hs  = s_axi_rd.arvalid & s_axi_rd.arready;
    assign w_r_hs   = s_axi_rd.rvalid & s_axi_rd.rready;
    assign w_rfinal = (r_rcnt == {1'b0, r_rlen});

    always_ff @(posedge clk) begin
        if (!rst_n) r_rstate <= R_IDLE;
        else        r_rstate <= w_rstate_nxt;
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            R_IDLE:  if (w_ar_hs) w_rstate_nxt = R_DATA;
            R_DATA:  if (w_r_hs && w_rfinal) w_rstate_nxt = R_IDLE;
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        s_axi_rd.arready = r_live && (r_rstate == R_IDLE);
        s_axi_rd.rvalid  = (r_rstate == R_DATA);
        s_axi_rd.rlast   = (r_rstate == R_DATA) && w_rfinal;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_arid <= '0; r_raddr <= '0; r_rlen <= '0; r_rburst <= '0;
            r_rcnt <= '0; r_rerr <= 1'b0;
        end else if (w_ar_hs) begin
            r_arid   <= s_axi_rd.arid;
            r_raddr  <= align(s_axi_rd.araddr);
            r_rlen   <= s_axi_rd.arlen;
            r_rburst <= s_axi_rd.arburst;
            r_rcnt   <= '0;
            r_rerr   <= burst_err(s_axi_rd.araddr, s_axi_rd.arlen,
                                  s_axi_rd.arsize, s_axi_rd.arburst);
        end else if (w_r_hs && !w_rfinal) begin
            r_raddr <= next_addr(r_raddr, r_rburst);
            r_rcnt  <= r_rcnt + 9'd1;
        end
    end

    // Prefetch: the AR handshake reads beat 0, each non-final R handshake
    // reads the following beat, so rdata is ready one cycle later and stays
    // frozen (no read strobe) while the master stalls.
    assign w_mem_re    = w_ar_hs || (w_r_hs && !w_rfinal);
    assign w_mem_raddr = w_ar_hs ? word_idx(align(s_axi_rd.araddr))
                                 : word_idx(next_addr(r_raddr, r_rburst));

    assign s_axi_rd.rid   = r_arid;
    assign s_axi_rd.rdata = r_rerr ? '0 : w_mem_rdata;
    assign s_axi_rd.rresp = r_rerr ? RESP_SLVERR : RESP_OKAY;
    assign s_axi_rd.ruser = 1'b0;

    axi_sram_mem #(
        .DATA_W (DATA_W),
        .WORDS  (c_WORDS),
        .IDX_W  (c_IDX_W)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_w_hs && !r_werr && rst_n),
        .i_waddr (word_idx(r_waddr)),
        .i_wdata (s_axi_wr.wdata),
        .i_wstrb (s_axi_wr.wstrb),
        .i_re    (w_mem_re),
        .i_raddr (w_mem_raddr),
        .o_rdata (w_mem_rdata)
    );

    // Sideband inputs carry no meaning for a plain SRAM.
    logic w_unused;
    assign w_unused = ^{s_axi_wr.awlock, s_axi_wr.awcache, s_axi_wr.awprot, s_axi_wr.awqos,
                        s_axi_wr.awregion, s_axi_wr.awuser, s_axi_wr.wuser,
                        s_axi_rd.arlock, s_axi_rd.arcache, s_axi_rd.arprot, s_axi_rd.arqos,
                        s_axi_rd.arregion, s_axi_rd.aruser};
endmodule
`default_nettype wire

// File: tb/tb_axi_sram_slv.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_sram_slv
//  Description : Self-checking bench for axi_sram_slv: table of write/readback
//                bursts plus hand-written stall, read-first and reset cases.
//                Read beats are checked against a scoreboard queue filled from
//                a bench-side word model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_sram_slv;
    import axi_sram_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    axi_interface_if #(.DATA_W(64), .ADDR_W(64), .ID_W(8)) axi_if ();

    axi_sram_slv #(
        .DATA_W(64), .ADDR_W(64), .ID_W(8), .MEM_BYTES(65536), .BASE_ADDR(64'h0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .s_axi_wr(axi_if), .s_axi_rd(axi_if)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [7:0]  id;
    } rexp_t;
    rexp_t exp_q[$];

    logic [63:0] model [logic [63:0]];

    typedef struct {
        logic [63:0] addr;
        logic [7:0]  len;
        logic [1:0]  burst;
        logic [2:0]  size;
        logic [63:0] seed;
        logic [7:0]  strb;
        logic        w_err;
        logic        r_err;
    } vec_t;
    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic aw_send(input logic [7:0] id, input logic [63:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        axi_if.awvalid = 1'b1; axi_if.awid = id; axi_if.awaddr = addr;
        axi_if.awlen = len; axi_if.awsize = size; axi_if.awburst = burst;
        while (!axi_if.awready && n < 50) begin @(negedge clk); n++; end
        chk("aw_ready", axi_if.awready, 1);
        @(negedge clk);
        axi_if.awvalid = 1'b0;
    endtask

    task automatic ar_send(input logic [7:0] id, input logic [63:0] addr, input logic [7:0] len,
                           input logic [1:0] burst);
        int n = 0;
        axi_if.arvalid = 1'b1; axi_if.arid = id; axi_if.araddr = addr;
        axi_if.arlen = len; axi_if.arsize = 3'd3; axi_if.arburst = burst;
        while (!axi_if.arready && n < 50) begin @(negedge clk); n++; end
        chk("ar_ready", axi_if.arready, 1);
        @(negedge clk);
        axi_if.arvalid = 1'b0;
    endtask

    task automatic b_recv(input logic [7:0] id, input logic [1:0] resp);
        int n = 0;
        axi_if.bready = 1'b1;
        while (!axi_if.bvalid && n < 50) begin @(negedge clk); n++; end
        chk("b_valid", axi_if.bvalid, 1);
        chk("b_id", axi_if.bid, id);
        chk("b_resp", axi_if.bresp, resp);
        @(negedge clk);
        axi_if.bready = 1'b0;
    endtask

    task automatic write_burst(input logic [7:0] id, input logic [63:0] addr, input logic [7:0] len,
                               input logic [2:0] size, input logic [1:0] burst,
                               input logic [63:0] seed, input logic [7:0] strb,
                               input int last_at, input logic err, input logic [1:0] resp);
        logic [63:0] k, d, old;
        int n;
        aw_send(id, addr, len, size, burst);
        for (int i = 0; i <= int'(len); i++) begin
            d = seed + 64'(i);
            axi_if.wvalid = 1'b1; axi_if.wdata = d; axi_if.wstrb = strb;
            axi_if.wlast = (i == last_at);
            n = 0;
            while (!axi_if.wready && n < 50) begin @(negedge clk); n++; end
            chk("w_ready", axi_if.wready, 1);
            @(negedge clk);
            if (!err) begin
                k   = (addr & ~64'h7) + ((burst == BURST_INCR) ? 64'(8 * i) : 64'h0);
                old = model.exists(k) ? model[k] : 64'h0;
                for (int b = 0; b < 8; b++) if (strb[b]) old[b*8 +: 8] = d[b*8 +: 8];
                model[k] = old;
            end
        end
        axi_if.wvalid = 1'b0; axi_if.wlast = 1'b0;
        b_recv(id, resp);
    endtask

    task automatic r_recv(input int nbeats, input logic [3:0] pat);
        int got = 0, cyc = 0, k = 0;
        logic held = 1'b0;
        logic [63:0] s_data;
        logic [10:0] s_ctl;
        rexp_t e;
        while (got < nbeats && cyc < 200) begin
            axi_if.rready = pat[k % 4];
            k++;
            if (axi_if.rvalid) begin
                if (held) begin
                    chk("r_stall_data", axi_if.rdata, s_data);
                    chk("r_stall_ctl", {axi_if.rid, axi_if.rresp, axi_if.rlast}, s_ctl);
                end
                if (axi_if.rready) begin
                    if (exp_q.size() == 0) begin
                        chk("r_unexpected_beat", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("r_data", axi_if.rdata, e.data);
                        chk("r_resp", axi_if.rresp, e.resp);
                        chk("r_last", axi_if.rlast, e.last);
                        chk("r_id", axi_if.rid, e.id);
                    end
                    got++;
                    held = 1'b0;
                end else begin
                    s_data = axi_if.rdata;
                    s_ctl  = {axi_if.rid, axi_if.rresp, axi_if.rlast};
                    held   = 1'b1;
                end
            end
            @(negedge clk);
            cyc++;
        end
        axi_if.rready = 1'b0;
        chk("r_beat_count", got, nbeats);
        chk("r_done_idle", axi_if.rvalid, 0);
    endtask

    task automatic read_burst(input logic [7:0] id, input logic [63:0] addr, input logic [7:0] len,
                              input logic [1:0] burst, input logic err, input logic [3:0] pat);
        logic [63:0] k;
        rexp_t e;
        for (int i = 0; i <= int'(len); i++) begin
            k      = (addr & ~64'h7) + ((burst == BURST_INCR) ? 64'(8 * i) : 64'h0);
            e.data = err ? 64'h0 : (model.exists(k) ? model[k] : 64'h0);
            e.resp = err ? RESP_SLVERR : RESP_OKAY;
            e.last = (i == int'(len));
            e.id   = id;
            exp_q.push_back(e);
        end
        ar_send(id, addr, len, burst);
        chk("r_first_beat_latency", axi_if.rvalid, 1);
        r_recv(int'(len) + 1, pat);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=running want=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{64'h40,   8'd3, BURST_INCR,  3'd3, 64'h1,                8'hFF, 1'b0, 1'b0};
        vecs[1] = '{64'h100,  8'd0, BURST_INCR,  3'd3, 64'h1122334455667788, 8'hFF, 1'b0, 1'b0};
        vecs[2] = '{64'h100,  8'd0, BURST_INCR,  3'd3, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 1'b0, 1'b0};
        vecs[3] = '{64'h200,  8'd7, BURST_FIXED, 3'd3, 64'h50,               8'hFF, 1'b0, 1'b0};
        vecs[4] = '{64'h300,  8'd1, BURST_INCR,  3'd3, 64'h77,               8'hFF, 1'b0, 1'b0};
        vecs[5] = '{64'h300,  8'd1, BURST_INCR,  3'd2, 64'h99,               8'hFF, 1'b1, 1'b0};
        vecs[6] = '{64'h400,  8'd3, BURST_WRAP,  3'd3, 64'h5,                8'hFF, 1'b1, 1'b1};
        vecs[7] = '{64'hFFF8, 8'd1, BURST_INCR,  3'd3, 64'h3,                8'hFF, 1'b1, 1'b1};
        vecs[8] = '{64'hFFF8, 8'd0, BURST_INCR,  3'd3, 64'hCAFE,             8'hFF, 1'b0, 1'b0};
        vecs[9] = '{64'h500,  8'd1, 2'b11,       3'd3, 64'h9,                8'hFF, 1'b1, 1'b1};

        rst_n = 1'b0;
        axi_if.awvalid = 0; axi_if.awid = 0; axi_if.awaddr = 0; axi_if.awlen = 0;
        axi_if.awsize = 0; axi_if.awburst = 0; axi_if.awlock = 0; axi_if.awcache = 0;
        axi_if.awprot = 0; axi_if.awqos = 0; axi_if.awregion = 0; axi_if.awuser = 0;
        axi_if.wvalid = 0; axi_if.wdata = 0; axi_if.wstrb = 0; axi_if.wlast = 0;
        axi_if.wuser = 0; axi_if.bready = 0;
        axi_if.arvalid = 0; axi_if.arid = 0; axi_if.araddr = 0; axi_if.arlen = 0;
        axi_if.arsize = 0; axi_if.arburst = 0; axi_if.arlock = 0; axi_if.arcache = 0;
        axi_if.arprot = 0; axi_if.arqos = 0; axi_if.arregion = 0; axi_if.aruser = 0;
        axi_if.rready = 0;

        repeat (3) @(negedge clk);
        chk("rst_readies", {axi_if.awready, axi_if.arready, axi_if.wready}, 0);
        chk("rst_valids", {axi_if.bvalid, axi_if.rvalid, axi_if.rlast}, 0);
        chk("rst_ids", {axi_if.bid, axi_if.rid}, 0);
        chk("rst_resps", {axi_if.bresp, axi_if.rresp}, 0);
        chk("rst_rdata", axi_if.rdata, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_awready", axi_if.awready, 1);
        chk("post_rst_arready", axi_if.arready, 1);

        for (int v = 0; v < 10; v++) begin
            write_burst(8'h10 + 8'(v), vecs[v].addr, vecs[v].len, vecs[v].size, vecs[v].burst,
                        vecs[v].seed, vecs[v].strb, int'(vecs[v].len), vecs[v].w_err,
                        vecs[v].w_err ? RESP_SLVERR : RESP_OKAY);
            read_burst(8'h80 + 8'(v), vecs[v].addr, vecs[v].len, vecs[v].burst,
                       vecs[v].r_err, 4'hF);
        end

        // Partial-strobe merge against a literal value.
        exp_q.push_back('{64'h11223344AAAAAAAA, RESP_OKAY, 1'b1, 8'h20});
        ar_send(8'h20, 64'h100, 8'd0, BURST_INCR);
        r_recv(1, 4'hF);

        // 8-beat read with rready pattern 1,0,0,1.
        write_burst(8'h30, 64'h800, 8'd7, 3'd3, BURST_INCR, 64'h1000, 8'hFF, 7, 1'b0, RESP_OKAY);
        read_burst(8'h31, 64'h800, 8'd7, BURST_INCR, 1'b0, 4'b1001);

        // Write one past the window must not alias onto word 0.
        write_burst(8'h40, 64'h0, 8'd1, 3'd3, BURST_INCR, 64'hDEAD0000, 8'hFF, 1, 1'b0, RESP_OKAY);
        write_burst(8'h41, 64'h10000, 8'd1, 3'd3, BURST_INCR, 64'h5555, 8'hFF, 1, 1'b1, RESP_SLVERR);
        read_burst(8'h42, 64'h0, 8'd1, BURST_INCR, 1'b0, 4'hF);
        read_burst(8'h43, 64'h40, 8'd3, BURST_WRAP, 1'b1, 4'hF);

        // Early wlast: all three beats still taken and written, SLVERR.
        write_burst(8'h50, 64'hA00, 8'd2, 3'd3, BURST_INCR, 64'h700, 8'hFF, 1, 1'b0, RESP_SLVERR);
        read_burst(8'h51, 64'hA00, 8'd2, BURST_INCR, 1'b0, 4'hF);

        // Same-cycle write and read of one word returns the old data.
        write_burst(8'h60, 64'h900, 8'd0, 3'd3, BURST_INCR, 64'hA0A0, 8'hFF, 0, 1'b0, RESP_OKAY);
        aw_send(8'h61, 64'h900, 8'd0, 3'd3, BURST_INCR);
        exp_q.push_back('{64'hA0A0, RESP_OKAY, 1'b1, 8'h62});
        axi_if.wvalid = 1'b1; axi_if.wdata = 64'hB0B0; axi_if.wstrb = 8'hFF; axi_if.wlast = 1'b1;
        axi_if.arvalid = 1'b1; axi_if.arid = 8'h62; axi_if.araddr = 64'h900;
        axi_if.arlen = 8'd0; axi_if.arsize = 3'd3; axi_if.arburst = BURST_INCR;
        chk("rf_wready", axi_if.wready, 1);
        chk("rf_arready", axi_if.arready, 1);
        @(negedge clk);
        axi_if.wvalid = 1'b0; axi_if.wlast = 1'b0; axi_if.arvalid = 1'b0;
        model[64'h900] = 64'hB0B0;
        r_recv(1, 4'hF);
        b_recv(8'h61, RESP_OKAY);
        read_burst(8'h63, 64'h900, 8'd0, BURST_INCR, 1'b0, 4'hF);

        // Reset in the middle of a read burst.
        ar_send(8'h70, 64'h800, 8'd7, BURST_INCR);
        axi_if.rready = 1'b1;
        @(negedge clk);
        chk("mid_rst_beat2_valid", axi_if.rvalid, 1);
        axi_if.rready = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_rvalid", axi_if.rvalid, 0);
        chk("mid_rst_readies", {axi_if.arready, axi_if.awready}, 0);
        chk("mid_rst_rdata", axi_if.rdata, 0);
        chk("mid_rst_rid", axi_if.rid, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_arready_after", axi_if.arready, 1);
        chk("mid_rst_awready_after", axi_if.awready, 1);
        chk("mid_rst_no_rvalid", axi_if.rvalid, 0);
        read_burst(8'h71, 64'h40, 8'd3, BURST_INCR, 1'b0, 4'hF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
